// File: rtl/unit_a.sv
// 32-bit registered arithmetic slice: sum / sub / invert-A / increment with carry and overflow flags.
// Optional registered zero flag Z is built when UNIT_A_ZERO_FLAG_EN is defined.

module unit_a_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module unit_a (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  f,
    output logic [31:0] S,
    output logic        c_out,
`ifdef UNIT_A_ZERO_FLAG_EN
    output logic        O,
    output logic        Z
`else
    output logic        O
`endif
);
    localparam logic [1:0] FN_SUM  = 2'b00;
    localparam logic [1:0] FN_SUB  = 2'b01;
    localparam logic [1:0] FN_AINV = 2'b10;
    localparam logic [1:0] FN_INC  = 2'b11;

    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic [32:0] c;
    logic [31:0] sum;
    logic [31:0] s_next;
    logic        c_next;
    logic        o_next;

    always_comb begin
        x   = A;
        y   = B;
        cin = 1'b0;
        case (f)
            FN_SUM:  begin y = B;     cin = 1'b0; end
            FN_SUB:  begin y = ~B;    cin = 1'b1; end
            FN_INC:  begin y = 32'd0; cin = 1'b1; end
            default: begin y = B;     cin = 1'b0; end
        endcase
    end

    // Ripple-carry chain; c[31] and c[32] give the signed-overflow detect.
    assign c[0] = cin;
    for (genvar i = 0; i < 32; i++) begin : g_rca
        unit_a_fa u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    always_comb begin
        s_next = sum;
        c_next = c[32];
        o_next = c[31] ^ c[32];
        if (f == FN_AINV) begin
            s_next = ~A;
            c_next = 1'b0;
            o_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            S     <= 32'd0;
            c_out <= 1'b0;
            O     <= 1'b0;
        end else begin
            S     <= s_next;
            c_out <= c_next;
            O     <= o_next;
        end
    end

`ifdef UNIT_A_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) Z <= 1'b1;
        else     Z <= (s_next == 32'd0);
    end
`endif

endmodule

// File: tb/tb_unit_a.sv
// Self-checking bench for unit_a: directed plan followed by randomized operations
// against an arithmetic reference model. Z is checked when UNIT_A_ZERO_FLAG_EN is defined.

module tb_unit_a;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  f;
    logic [31:0] S;
    logic        c_out;
    logic        O;
`ifdef UNIT_A_ZERO_FLAG_EN
    logic        Z;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    unit_a dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .f     (f),
        .S     (S),
        .c_out (c_out),
`ifdef UNIT_A_ZERO_FLAG_EN
        .O     (O),
        .Z     (Z)
`else
        .O     (O)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (A=%08h B=%08h f=%0d rst=%0b)",
                     tag, got, exp, A, B, f, rst);
        end
    endtask

    // Reference: unsigned/signed arithmetic on wide integers; returns {S, c_out, O}.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] fn, input logic r);
        longint      sa;
        longint      sb;
        longint      sv;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [31:0] s;
        logic        co;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sv = 0;
        s  = 32'd0;
        co = 1'b0;
        if (r) return 34'd0;
        case (fn)
            2'b00: begin s = a + b; co = ((ua + ub) >> 32) != 0; sv = sa + sb; end
            2'b01: begin s = a - b; co = (a >= b);               sv = sa - sb; end
            2'b10: begin s = ~a;    co = 1'b0;                   sv = 0;       end
            default: begin s = a + 32'd1; co = (a == 32'hFFFF_FFFF); sv = sa + 1; end
        endcase
        return {s, co, (sv > 64'sd2147483647) || (sv < -64'sd2147483648)};
    endfunction

    task automatic step(input string tag, input logic r, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] fn);
        logic [33:0] e;
        @(negedge clk);
        rst = r; A = a; B = b; f = fn;
        e = model(a, b, fn, r);
        @(posedge clk);
        #1;
        chk({tag, ".S"}, S, e[33:2]);
        chk({tag, ".c_out"}, {31'd0, c_out}, {31'd0, e[1]});
        chk({tag, ".O"}, {31'd0, O}, {31'd0, e[0]});
`ifdef UNIT_A_ZERO_FLAG_EN
        chk({tag, ".Z"}, {31'd0, Z}, {31'd0, r || (e[33:2] == 32'd0)});
`endif
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; A = 32'd6; B = 32'd6; f = 2'b00;

        step("rst0", 1'b1, 32'd6, 32'd6, 2'b00);
        step("rst1", 1'b1, 32'd6, 32'd6, 2'b00);
        step("sum66", 1'b0, 32'd6, 32'd6, 2'b00);
        step("sub66", 1'b0, 32'd6, 32'd6, 2'b01);
        step("ainv0", 1'b0, 32'd0, 32'd6, 2'b10);
        step("inc0", 1'b0, 32'd0, 32'd6, 2'b11);
        step("addovf", 1'b0, 32'h7FFF_FFFF, 32'd1, 2'b00);
        step("subnov", 1'b0, 32'h7FFF_FFFF, 32'd1, 2'b01);
        step("subovf", 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b01);
        step("incwrap", 1'b0, 32'hFFFF_FFFF, 32'd1, 2'b11);
        step("incovf", 1'b0, 32'h7FFF_FFFF, 32'd0, 2'b11);
        step("incwrap2", 1'b0, 32'hFFFF_FFFF, 32'd1, 2'b11);
        step("b2bsum", 1'b0, 32'hFFFF_FFFF, 32'd1, 2'b00);
        step("midrst", 1'b1, 32'hFFFF_FFFF, 32'd1, 2'b00);
        step("postrst", 1'b0, 32'hFFFF_FFFF, 32'd1, 2'b00);

        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 15) == 0), pick(), pick(),
                 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
